pcileech_sysctl: RTL

PCILEECH_SYSCTL -- requirements
Module: pcileech_sysctl

---
 rtl/pcileech_sysctl_if.sv | 47 ++++
 rtl/pcileech_sysctl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_sysctl_if.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_sysctl_if
// Description : Signal bundle between the system-control block and its
//               surroundings (PCIe sideband pads, LED channels, wake request,
//               free-running tick counter and the generated resets).
//   master modport : the surrounding logic / pads (drives the inputs)
//   slave  modport : pcileech_sysctl (drives the outputs)
//   pcie_perst_n  PERST# from pad, asynchronous to clk
//   pcie_present  card-present strap
//   led_act       per-channel activity
//   led_blink_en  per-channel power-on blink enable
//   wake_req      single-clock wake request
//   tickcount64   free-running clock count
//   rst_out       active-high downstream system reset
//   pcie_rst      active-high PCIe-core reset
//   perst_sync_n  PERST# synchronised to clk
//   led           LED drive, 1 = lit
//   pcie_wake_n   WAKE# drive, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface pcileech_sysctl_if #(
    parameter int NUM_LED = 2
);
    logic               pcie_perst_n;
    logic               pcie_present;
    logic [NUM_LED-1:0] led_act;
    logic [NUM_LED-1:0] led_blink_en;
    logic               wake_req;
    logic [63:0]        tickcount64;
    logic               rst_out;
    logic               pcie_rst;
    logic               perst_sync_n;
    logic [NUM_LED-1:0] led;
    logic               pcie_wake_n;

    modport master (
        output pcie_perst_n, pcie_present, led_act, led_blink_en, wake_req,
        input  tickcount64, rst_out, pcie_rst, perst_sync_n, led, pcie_wake_n
    );

    modport slave (
        input  pcie_perst_n, pcie_present, led_act, led_blink_en, wake_req,
        output tickcount64, rst_out, pcie_rst, perst_sync_n, led, pcie_wake_n
    );
endinterface
`default_nettype wire

// File: rtl/pcileech_sysctl.sv
`default_nettype none
// ============================================================================
// Module      : pcileech_sysctl
// Description : System control: free-running 64-bit tick counter, PERST#
//               synchroniser, reset sequencer (HOLD/RUN/PERST/PREL) producing
//               rst_out and pcie_rst, stretched activity LEDs with power-on
//               blink, and a bounded WAKE# pulse generator.
// Ports       :
//   clk    in  : system clock, all logic on rising edge
//   rst_n  in  : asynchronous active-low reset
//   bus    slave modport of pcileech_sysctl_if (NUM_LED must match)
// Revision    : 1.0 - initial release
// ============================================================================
module pcileech_sysctl #(
    parameter int RST_HOLD_CYCLES   = 64,
    parameter int PERST_HOLD_CYCLES = 256,
    parameter int NUM_LED           = 2,
    parameter int STRETCH_BITS      = 22,
    parameter int BLINK_BIT         = 24,
    parameter int BLINK_WINDOW_BIT  = 27,
    parameter int WAKE_PULSE_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    pcileech_sysctl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_PERST = 2'd2,
        S_PREL  = 2'd3
    } state_t;

    localparam int c_WAKE_W = $clog2(WAKE_PULSE_CYCLES + 1);

    localparam logic [15:0]         c_HOLD_LAST = 16'(RST_HOLD_CYCLES - 1);
    // The PERST->PREL edge is itself the first clock after perst_sync_n rose,
    // so PREL terminates one count early to release pcie_rst exactly
    // PERST_HOLD_CYCLES clocks after the synchronised rising edge.
    localparam logic [15:0]         c_PREL_LAST = 16'(PERST_HOLD_CYCLES - 2);
    localparam logic [c_WAKE_W-1:0] c_WAKE_LAST = c_WAKE_W'(WAKE_PULSE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Tick counter
    // ------------------------------------------------------------------------
    logic [63:0] r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 64'd1;
        end
    end

    assign bus.tickcount64 = r_tick;

    // ------------------------------------------------------------------------
    // PERST# synchroniser
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pcie_perst_n;
            r_sync2 <= r_sync1;
        end
    end

    assign bus.perst_sync_n = r_sync2;

    // High on the edge at which perst_sync_n goes 0->1.
    logic w_perst_rise;
    assign w_perst_rise = r_sync1 & ~r_sync2;

    // ------------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_seq_cnt;
    logic [15:0] w_seq_cnt_nxt;
    logic        r_rst_out;
    logic        r_pcie_rst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_HOLD;
            r_seq_cnt  <= '0;
            r_rst_out  <= 1'b1;
            r_pcie_rst <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_seq_cnt  <= w_seq_cnt_nxt;
            r_rst_out  <= (w_state_nxt == S_HOLD);
            r_pcie_rst <= (w_state_nxt != S_RUN);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seq_cnt_nxt = r_seq_cnt + 16'd1;
        case (r_state)
            S_HOLD: begin
                if (r_seq_cnt == c_HOLD_LAST) begin
                    w_seq_cnt_nxt = '0;
                    w_state_nxt   = r_sync2 ? S_RUN : S_PERST;
                end
            end
            S_RUN: begin
                w_seq_cnt_nxt = '0;
                if (!r_sync2) begin
                    w_state_nxt = S_PERST;
                end
            end
            S_PERST: begin
                w_seq_cnt_nxt = '0;
                if (r_sync2) begin
                    w_state_nxt = S_PREL;
                end
            end
            S_PREL: begin
                if (!r_sync2) begin
                    w_seq_cnt_nxt = '0;
                    w_state_nxt   = S_PERST;
                end else if (r_seq_cnt == c_PREL_LAST) begin
                    w_seq_cnt_nxt = '0;
                    w_state_nxt   = S_RUN;
                end
            end
            default: begin
                w_seq_cnt_nxt = '0;
                w_state_nxt   = S_HOLD;
            end
        endcase
    end

    assign bus.rst_out  = r_rst_out;
    // An absent card keeps the core in reset without waiting for a clock.
    assign bus.pcie_rst = r_pcie_rst | ~bus.pcie_present;

    // ------------------------------------------------------------------------
    // LEDs: activity stretch with power-on blink overlay
    // ------------------------------------------------------------------------
    logic               w_blink;
    logic [NUM_LED-1:0] w_led_nxt;
    logic [NUM_LED-1:0] r_led;

    assign w_blink = r_tick[BLINK_BIT] & (r_tick[63:BLINK_WINDOW_BIT] == '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LED; gi++) begin : g_led
            logic [STRETCH_BITS-1:0] r_stretch;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stretch <= '0;
                end else if (bus.led_act[gi]) begin
                    r_stretch <= '1;
                end else if (r_stretch != '0) begin
                    r_stretch <= r_stretch - STRETCH_BITS'(1);
                end
            end

            assign w_led_nxt[gi] = (r_stretch != '0) ^ (w_blink & bus.led_blink_en[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    assign bus.led = r_led;

    // ------------------------------------------------------------------------
    // WAKE# pulse
    // ------------------------------------------------------------------------
    logic                r_wake_n;
    logic [c_WAKE_W-1:0] r_wake_cnt;
    logic                w_wake_start;

    assign w_wake_start = bus.wake_req & r_wake_n & bus.pcie_present & (r_state != S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wake_n   <= 1'b1;
            r_wake_cnt <= '0;
        end else if (!r_wake_n) begin
            // Host came out of PERST# on its own: the wake has served its purpose.
            if (w_perst_rise || (r_wake_cnt == c_WAKE_LAST)) begin
                r_wake_n   <= 1'b1;
                r_wake_cnt <= '0;
            end else begin
                r_wake_cnt <= r_wake_cnt + c_WAKE_W'(1);
            end
        end else if (w_wake_start) begin
            r_wake_n   <= 1'b0;
            r_wake_cnt <= '0;
        end
    end

    assign bus.pcie_wake_n = r_wake_n;

endmodule
`default_nettype wire
